// File: rtl/pr_hrav_reconfig_scheduler.sv
// Partial-reconfiguration scheduler for the two HRAV scanner cores.
// Picks one requesting core round-robin, drains and resets it, hands it the
// shared ICAP stream path, then releases it on cfg_done (or quarantines it
// on cfg_err / timeout). All outputs are registered.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE  (0) | waiting for a request; arbitrates on req
//   DRAIN (1) | core disabled, waiting for core_idle (bounded by DRAIN_TO)
//   PRE_RST(2)| core held in reset RST_PRE cycles before the ICAP grant
//   CONFIG(3) | ICAP path granted, waiting for cfg_done / cfg_err / timeout
//   POST_RST(4)| core held in reset RST_POST cycles after cfg_done
//   FINISH(5) | re-enable core, pulse done
module pr_hrav_reconfig_scheduler #(
  parameter int RST_PRE  = 8,
  parameter int RST_POST = 16,
  parameter int DRAIN_TO = 1024,
  parameter int CFG_TO_W = 24
) (
  input  logic       ACLK,
  input  logic       a_reset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_core_idle,
  input  logic       i_cfg_done,
  input  logic       i_cfg_err,
  output logic [1:0] o_cfg_grant,
  output logic [1:0] o_core_enb,
  output logic [1:0] o_core_rst,
  output logic [1:0] o_done,
  output logic [1:0] o_err,
  output logic [1:0] o_core_failed,
  output logic       o_busy,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_PRE_RST  = 3'd2,
    S_CONFIG   = 3'd3,
    S_POST_RST = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  // One shared counter serves every timed state; it is cleared on each state entry.
  localparam logic [CFG_TO_W-1:0] C_DRAIN_LAST = CFG_TO_W'(DRAIN_TO - 1);
  localparam logic [CFG_TO_W-1:0] C_PRE_LAST   = CFG_TO_W'(RST_PRE - 1);
  localparam logic [CFG_TO_W-1:0] C_POST_LAST  = CFG_TO_W'(RST_POST - 1);
  localparam logic [CFG_TO_W-1:0] C_CNT_MAX    = '1;

  state_t              r_state, w_state_nxt;
  logic                r_sel, w_sel_nxt;
  logic                r_ptr, w_ptr_nxt;
  logic [CFG_TO_W-1:0] r_cnt, w_cnt_nxt;

  logic [1:0] r_cfg_grant, w_cfg_grant_nxt;
  logic [1:0] r_core_enb, w_core_enb_nxt;
  logic [1:0] r_core_rst, w_core_rst_nxt;
  logic [1:0] r_done, w_done_nxt;
  logic [1:0] r_err, w_err_nxt;
  logic [1:0] r_core_failed, w_core_failed_nxt;

  logic w_pick;
  logic w_drain_last;
  logic w_pre_last;
  logic w_post_last;
  logic w_cfg_abort;

  // With both requests pending the pointer decides; otherwise the lone requester wins.
  assign w_pick       = (i_req == 2'b11) ? r_ptr : i_req[1];
  assign w_drain_last = (r_cnt == C_DRAIN_LAST);
  assign w_pre_last   = (r_cnt == C_PRE_LAST);
  assign w_post_last  = (r_cnt == C_POST_LAST);
  // cfg_err takes priority over a coincident cfg_done.
  assign w_cfg_abort  = i_cfg_err || (r_cnt == C_CNT_MAX);

  // State, bookkeeping and output registers; synchronous reset.
  always_ff @(posedge ACLK) begin
    if (a_reset) begin
      r_state       <= S_IDLE;
      r_sel         <= 1'b0;
      r_ptr         <= 1'b0;
      r_cnt         <= '0;
      r_cfg_grant   <= 2'b00;
      r_core_enb    <= 2'b11;
      r_core_rst    <= 2'b00;
      r_done        <= 2'b00;
      r_err         <= 2'b00;
      r_core_failed <= 2'b00;
    end else begin
      r_state       <= w_state_nxt;
      r_sel         <= w_sel_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cfg_grant   <= w_cfg_grant_nxt;
      r_core_enb    <= w_core_enb_nxt;
      r_core_rst    <= w_core_rst_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      r_core_failed <= w_core_failed_nxt;
    end
  end

  // Next state, selected core, round-robin pointer and shared counter.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_req != 2'b00) begin
          w_state_nxt = S_DRAIN;
          w_sel_nxt   = w_pick;
          w_ptr_nxt   = ~w_pick;
          w_cnt_nxt   = '0;
        end
      end
      S_DRAIN: begin
        if (i_core_idle[r_sel]) begin
          w_state_nxt = S_PRE_RST;
          w_cnt_nxt   = '0;
        end else if (w_drain_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PRE_RST: begin
        if (w_pre_last) begin
          w_state_nxt = S_CONFIG;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_CONFIG: begin
        if (w_cfg_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_cfg_done) begin
          w_state_nxt = S_POST_RST;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_POST_RST: begin
        if (w_post_last) begin
          w_state_nxt = S_FINISH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs; only the selected core's bits move.
  always_comb begin
    w_cfg_grant_nxt   = r_cfg_grant;
    w_core_enb_nxt    = r_core_enb;
    w_core_rst_nxt    = r_core_rst;
    w_core_failed_nxt = r_core_failed;
    w_done_nxt        = 2'b00;
    w_err_nxt         = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (i_req != 2'b00) w_core_enb_nxt[w_pick] = 1'b0;
      end
      S_DRAIN: begin
        if (i_core_idle[r_sel]) begin
          w_core_rst_nxt[r_sel] = 1'b1;
        end else if (w_drain_last) begin
          w_core_enb_nxt[r_sel] = 1'b1;
          w_err_nxt[r_sel]      = 1'b1;
        end
      end
      S_PRE_RST: begin
        if (w_pre_last) w_cfg_grant_nxt = r_sel ? 2'b10 : 2'b01;
      end
      S_CONFIG: begin
        // On failure the core is left disabled and in reset (quarantined).
        if (w_cfg_abort) begin
          w_cfg_grant_nxt          = 2'b00;
          w_err_nxt[r_sel]         = 1'b1;
          w_core_failed_nxt[r_sel] = 1'b1;
        end else if (i_cfg_done) begin
          w_cfg_grant_nxt = 2'b00;
        end
      end
      S_POST_RST: begin
        if (w_post_last) w_core_rst_nxt[r_sel] = 1'b0;
      end
      S_FINISH: begin
        w_core_enb_nxt[r_sel]    = 1'b1;
        w_done_nxt[r_sel]        = 1'b1;
        w_core_failed_nxt[r_sel] = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign o_cfg_grant   = r_cfg_grant;
  assign o_core_enb    = r_core_enb;
  assign o_core_rst    = r_core_rst;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_core_failed = r_core_failed;
  assign o_busy        = (r_state != S_IDLE);
  assign o_state       = r_state;

endmodule
